// File: rtl/hpdsm_feeder.sv
// Sample scheduler in front of the delta-sigma modulator: FIFO, clamp on pop,
// and linear interpolation at the modulator clock rate with soft start/stop.
module hpdsm_feeder #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int RATE_LOG2  = 8,
  parameter int CLAMP      = 24576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] xo,
  output logic                    tick,
  output logic                    running,
  input  logic                    clr_status,
  output logic                    underflow,
  output logic                    overload
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int AW     = WIDTH + RATE_LOG2;
  localparam int STEP_W = WIDTH + 1;
  localparam logic [RATE_LOG2-1:0]      CNT_LAST = '1;
  localparam logic [DEPTH_LOG2:0]       FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic signed [WIDTH-1:0]   LIM_P    = WIDTH'(CLAMP);
  localparam logic signed [WIDTH-1:0]   LIM_N    = WIDTH'(-CLAMP);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    full, empty, push, pop;

  logic signed [AW-1:0]     acc;
  logic signed [STEP_W-1:0] step;
  logic signed [WIDTH-1:0]  tgt;
  logic [RATE_LOG2-1:0]     cnt;

  logic signed [WIDTH-1:0]  head, head_c;
  logic                     head_ovl, boundary;
  logic                     start, seg_next, seg_drain, seg_hold;

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] s);
    if (s > LIM_P)      return LIM_P;
    else if (s < LIM_N) return LIM_N;
    else                return s;
  endfunction

  function automatic logic is_clamped(input logic signed [WIDTH-1:0] s);
    return (s > LIM_P) || (s < LIM_N);
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign s_ready = ~rst & ~full;
  assign push    = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: ;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign head_c   = clamp(head);
  assign head_ovl = is_clamped(head);
  assign boundary = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !empty) state_nxt = RUN;
      RUN:     if (boundary && !en) state_nxt = DRAIN;
      DRAIN:   if (boundary) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    start     = 1'b0;
    seg_next  = 1'b0;
    seg_drain = 1'b0;
    seg_hold  = 1'b0;
    case (state)
      IDLE: if (en && !empty) begin
        pop   = 1'b1;
        start = 1'b1;
      end
      RUN: if (boundary) begin
        if (!en) seg_drain = 1'b1;
        else if (!empty) begin
          pop      = 1'b1;
          seg_next = 1'b1;
        end else seg_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Each segment adds step exactly P times, so acc lands on tgt*P at the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      step <= '0;
      tgt  <= '0;
      cnt  <= '0;
    end else if (state == IDLE) begin
      acc  <= '0;
      cnt  <= '0;
      tgt  <= start ? head_c : '0;
      step <= start ? STEP_W'(head_c) : '0;
    end else begin
      acc <= acc + AW'(step);
      cnt <= cnt + RATE_LOG2'(1);
      if (seg_next) begin
        step <= STEP_W'(head_c) - STEP_W'(tgt);
        tgt  <= head_c;
      end else if (seg_drain) begin
        step <= -STEP_W'(tgt);
        tgt  <= '0;
      end else if (seg_hold) begin
        step <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      overload  <= 1'b0;
    end else begin
      underflow <= seg_hold | (underflow & ~clr_status);
      overload  <= (pop & head_ovl) | (overload & ~clr_status);
    end
  end

  assign xo      = acc[AW-1:RATE_LOG2];
  assign running = (state != IDLE);
  assign tick    = (state != IDLE) && (cnt == '0);

endmodule

// File: tb/tb_hpdsm_feeder.sv
// Bench for hpdsm_feeder: queue-and-segment reference model checked every cycle,
// plus directed sequences with hand-computed values.
module tb_hpdsm_feeder;
  localparam int W     = 16;
  localparam int DL2   = 2;
  localparam int RL2   = 2;
  localparam int P     = 1 << RL2;
  localparam int DEPTH = 1 << DL2;
  localparam int LIM   = 24576;

  logic clk, rst, en, s_valid, s_ready, tick, running, clr_status, underflow, overload;
  logic signed [W-1:0] s_data, xo;

  hpdsm_feeder #(.WIDTH(W), .DEPTH_LOG2(DL2), .RATE_LOG2(RL2), .CLAMP(LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .xo(xo), .tick(tick), .running(running),
    .clr_status(clr_status), .underflow(underflow), .overload(overload)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int v);
    if (v >= 0) return v / P;
    return -((-v + P - 1) / P);
  endfunction

  function automatic int clampm(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  // Reference: sample queue, and a segment from value a to value b at phase ph.
  int q[$];
  int mst;      // 0 idle, 1 run, 2 drain
  int ma, mb, mph;
  bit m_unf, m_ovl, mvalid;
  int pv;
  bit dp, popped, setu, pclamp;

  initial begin
    mst = 0; ma = 0; mb = 0; mph = 0; m_unf = 0; m_ovl = 0; mvalid = 0;
  end

  always @(posedge clk) begin
    mvalid <= 1'b1;
    if (rst) begin
      q.delete();
      mst = 0; ma = 0; mb = 0; mph = 0; m_unf = 0; m_ovl = 0;
    end else begin
      dp = s_valid && (q.size() < DEPTH);
      popped = 0; setu = 0; pclamp = 0;
      if (mst == 0) begin
        if (en && q.size() > 0) begin
          pv = q.pop_front(); popped = 1;
          ma = 0; mb = clampm(pv); mph = 0; mst = 1;
        end
      end else if (mph == P - 1) begin
        ma = mb; mph = 0;
        if (mst == 2) begin
          mst = 0; ma = 0; mb = 0;
        end else if (!en) begin
          mst = 2; mb = 0;
        end else if (q.size() > 0) begin
          pv = q.pop_front(); popped = 1; mb = clampm(pv);
        end else setu = 1;
      end else mph++;
      if (popped) pclamp = (clampm(pv) != pv);
      if (dp) q.push_back(int'(s_data));
      m_unf = setu | (m_unf & !clr_status);
      m_ovl = (popped & pclamp) | (m_ovl & !clr_status);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("xo", int'(xo), fdiv(ma * P + mph * (mb - ma)));
      chk("tick", int'(tick), int'(mst != 0 && mph == 0));
      chk("running", int'(running), int'(mst != 0));
      chk("s_ready", int'(s_ready), int'(!rst && q.size() < DEPTH));
      chk("underflow", int'(underflow), int'(m_unf));
      chk("overload", int'(overload), int'(m_ovl));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; clr_status = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; clr_status = 1'b0;

    // Reset values
    repeat (3) cyc();
    chk("rst_xo", int'(xo), 0);
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_flags", int'({underflow, overload}), 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", int'(s_ready), 1);

    // Fill with en=0: 4 accepted, 5th refused
    for (int i = 0; i < 5; i++) begin
      s_data = W'(100 * (i + 1)); s_valid = 1'b1;
      #1;
      chk("ready_fill", int'(s_ready), int'(i < 4));
      cyc();
    end
    s_valid = 1'b0; en = 1'b1;
    cyc();
    chk("ready_after_pop", int'(s_ready), 1);
    repeat (20) cyc();
    en = 1'b0;
    repeat (12) cyc();

    // Single sample 400, underflow, then clamped 30000
    do_reset();
    s_data = 16'sd400; s_valid = 1'b1;
    cyc();
    s_valid = 1'b0; en = 1'b1;
    cyc();
    chk("first_xo0", int'(xo), 0);
    chk("first_tick", int'(tick), 1);
    chk("first_running", int'(running), 1);
    cyc(); chk("ramp_100", int'(xo), 100); chk("ramp_tick0", int'(tick), 0);
    cyc(); chk("ramp_200", int'(xo), 200);
    cyc(); chk("ramp_300", int'(xo), 300);
    cyc(); chk("ramp_400", int'(xo), 400); chk("unf_set", int'(underflow), 1);
    clr_status = 1'b1; s_data = 16'sd30000; s_valid = 1'b1;
    cyc();
    clr_status = 1'b0; s_valid = 1'b0;
    chk("unf_clr", int'(underflow), 0);
    chk("hold_400", int'(xo), 400);
    cyc(); cyc(); cyc();
    chk("ovl_set", int'(overload), 1);
    chk("seg_start_400", int'(xo), 400);
    cyc(); chk("clamp_6444", int'(xo), 6444);
    cyc(); chk("clamp_12488", int'(xo), 12488);
    cyc(); chk("clamp_18532", int'(xo), 18532);
    cyc(); chk("clamp_24576", int'(xo), 24576);
    clr_status = 1'b1;
    cyc();
    clr_status = 1'b0;
    chk("ovl_clr", int'(overload), 0);

    // Drain with queued samples, then reset mid-ramp
    do_reset();
    s_data = 16'sd400; s_valid = 1'b1;
    cyc();
    s_valid = 1'b0; en = 1'b1;
    cyc();
    s_data = 16'sd1000; s_valid = 1'b1;
    cyc();
    s_data = 16'sd2000;
    cyc();
    s_valid = 1'b0; en = 1'b0;
    cyc(); chk("pre_drain_300", int'(xo), 300);
    cyc(); chk("drain_400", int'(xo), 400); chk("drain_running", int'(running), 1);
    cyc(); chk("drain_300", int'(xo), 300);
    cyc(); chk("drain_200", int'(xo), 200);
    cyc(); chk("drain_100", int'(xo), 100);
    cyc(); chk("drain_0", int'(xo), 0); chk("drain_idle", int'(running), 0);
    en = 1'b1;
    cyc(); chk("restart_0", int'(xo), 0); chk("restart_run", int'(running), 1);
    cyc(); chk("restart_250", int'(xo), 250);
    rst = 1'b1;
    cyc();
    chk("midrst_xo", int'(xo), 0);
    chk("midrst_running", int'(running), 0);
    chk("midrst_ready", int'(s_ready), 0);
    rst = 1'b0;
    cyc(); cyc();
    chk("flushed_idle", int'(running), 0);
    en = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int pv_pct;
      pv_pct = ((i / 400) % 2 == 1) ? 15 : 45;
      s_valid = ($urandom_range(0, 99) < pv_pct);
      if ($urandom_range(0, 1) == 1) s_data = W'($urandom_range(0, 65535));
      else s_data = W'(int'($urandom_range(0, 2000)) - 1000);
      if ($urandom_range(0, 59) == 0) en = ~en;
      clr_status = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0; s_valid = 1'b0; clr_status = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
